// File: rtl/matrix_ascii_tx_if.sv
// Storage read port and UART TX byte handshake used by matrix_ascii_tx.
// master = the serializer, slave = storage/UART side.
interface matrix_ascii_tx_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14
) ();
    logic [ADDR_WIDTH-1:0] storage_rd_addr;
    logic [DATA_WIDTH-1:0] storage_rd_data;
    logic [7:0]            uart_tx_data;
    logic                  uart_tx_valid;
    logic                  uart_tx_ready;

    modport master (
        output storage_rd_addr,
        input  storage_rd_data,
        output uart_tx_data,
        output uart_tx_valid,
        input  uart_tx_ready
    );

    modport slave (
        input  storage_rd_addr,
        output storage_rd_data,
        input  uart_tx_data,
        input  uart_tx_valid,
        output uart_tx_ready
    );
endinterface

// File: rtl/matrix_ascii_tx.sv
// Streams a stored matrix as ASCII decimal text: header "R C\n", then
// row-major signed elements separated by ' ' with '\n' at each row end.
module matrix_ascii_tx #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14,
    parameter int DIM_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIM_WIDTH-1:0]  rows,
    input  logic [DIM_WIDTH-1:0]  cols,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    matrix_ascii_tx_if.master     bus
);
    typedef enum logic [2:0] {IDLE, HDR, RD_ADDR, RD_WAIT, CONV, EMIT, SEP, FIN} state_t;

    localparam logic [DATA_WIDTH:0]   TEN      = (DATA_WIDTH+1)'(10);
    localparam logic [DIM_WIDTH-1:0]  DIM_ONE  = DIM_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    state_t                state_q, state_d;
    logic [DIM_WIDTH-1:0]  rows_q, rows_d, cols_q, cols_d, r_q, r_d, c_q, c_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d, idx_q, idx_d;
    logic                  err_q, err_d, hdr_q, hdr_d, hdr_col_q, hdr_col_d, sign_q, sign_d;
    logic [DATA_WIDTH:0]   mag_q, mag_d;
    logic [3:0]            ndig_q, ndig_d;
    logic [3:0]            dig_q [10];
    logic [3:0]            dig_d [10];

    logic [DATA_WIDTH:0]   quot, rd_ext;
    logic [3:0]            digit;
    logic                  accept, last_col, last_row;

    assign quot     = mag_q / TEN;
    assign digit    = 4'(mag_q - quot * TEN);
    assign rd_ext   = {bus.storage_rd_data[DATA_WIDTH-1], bus.storage_rd_data};
    assign last_col = (c_q == cols_q - DIM_ONE);
    assign last_row = (r_q == rows_q - DIM_ONE);
    assign accept   = bus.uart_tx_valid && bus.uart_tx_ready;

    // Element index counts row-major, so base + index equals base + r*cols + c.
    assign bus.storage_rd_addr = base_q + idx_q;

    assign busy  = (state_q != IDLE) && (state_q != FIN);
    assign done  = (state_q == FIN);
    assign error = (state_q == FIN) && err_q;

    always_comb begin
        bus.uart_tx_valid = 1'b0;
        bus.uart_tx_data  = 8'h00;
        case (state_q)
            EMIT: begin
                bus.uart_tx_valid = 1'b1;
                bus.uart_tx_data  = sign_q ? 8'h2D : 8'h30 + {4'h0, dig_q[ndig_q - 4'd1]};
            end
            SEP: begin
                bus.uart_tx_valid = 1'b1;
                bus.uart_tx_data  = (hdr_q ? hdr_col_q : last_col) ? 8'h0A : 8'h20;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        rows_d    = rows_q;
        cols_d    = cols_q;
        base_d    = base_q;
        r_d       = r_q;
        c_d       = c_q;
        idx_d     = idx_q;
        err_d     = err_q;
        hdr_d     = hdr_q;
        hdr_col_d = hdr_col_q;
        sign_d    = sign_q;
        mag_d     = mag_q;
        ndig_d    = ndig_q;
        dig_d     = dig_q;
        case (state_q)
            IDLE: if (start) begin
                rows_d    = rows;
                cols_d    = cols;
                base_d    = base_addr;
                r_d       = '0;
                c_d       = '0;
                idx_d     = '0;
                hdr_d     = 1'b1;
                hdr_col_d = 1'b0;
                err_d     = (rows == '0) || (cols == '0);
                state_d   = ((rows == '0) || (cols == '0)) ? FIN : HDR;
            end
            HDR: begin
                sign_d  = 1'b0;
                mag_d   = hdr_col_q ? (DATA_WIDTH+1)'(cols_q) : (DATA_WIDTH+1)'(rows_q);
                ndig_d  = '0;
                state_d = CONV;
            end
            RD_ADDR: state_d = RD_WAIT;
            RD_WAIT: begin
                sign_d  = rd_ext[DATA_WIDTH];
                mag_d   = rd_ext[DATA_WIDTH] ? -rd_ext : rd_ext;
                ndig_d  = '0;
                state_d = CONV;
            end
            // Least-significant digit lands in slot 0; EMIT walks the buffer downward.
            CONV: begin
                if (ndig_q < 4'd10) dig_d[ndig_q] = digit;
                ndig_d = ndig_q + 4'd1;
                mag_d  = quot;
                if (quot == '0) state_d = EMIT;
            end
            EMIT: if (accept) begin
                if (sign_q) begin
                    sign_d = 1'b0;
                end else begin
                    ndig_d = ndig_q - 4'd1;
                    if (ndig_q == 4'd1) state_d = SEP;
                end
            end
            SEP: if (accept) begin
                if (hdr_q) begin
                    hdr_col_d = 1'b1;
                    hdr_d     = !hdr_col_q;
                    state_d   = hdr_col_q ? RD_ADDR : HDR;
                end else if (last_col && last_row) begin
                    state_d = FIN;
                end else begin
                    c_d     = last_col ? '0 : c_q + DIM_ONE;
                    r_d     = last_col ? r_q + DIM_ONE : r_q;
                    idx_d   = idx_q + ADDR_ONE;
                    state_d = RD_ADDR;
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rows_q    <= '0;
            cols_q    <= '0;
            base_q    <= '0;
            r_q       <= '0;
            c_q       <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            hdr_q     <= 1'b0;
            hdr_col_q <= 1'b0;
            sign_q    <= 1'b0;
            mag_q     <= '0;
            ndig_q    <= '0;
            for (int i = 0; i < 10; i++) dig_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            rows_q    <= rows_d;
            cols_q    <= cols_d;
            base_q    <= base_d;
            r_q       <= r_d;
            c_q       <= c_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            hdr_q     <= hdr_d;
            hdr_col_q <= hdr_col_d;
            sign_q    <= sign_d;
            mag_q     <= mag_d;
            ndig_q    <= ndig_d;
            dig_q     <= dig_d;
        end
    end
endmodule

// File: tb/tb_matrix_ascii_tx.sv
// Directed self-checking bench for matrix_ascii_tx: byte streams, address
// order, handshake stability, zero-dimension errors and mid-run reset.
module tb_matrix_ascii_tx;
    localparam int DW   = 32;
    localparam int AW   = 14;
    localparam int DIMW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [DIMW-1:0] rows = '0;
    logic [DIMW-1:0] cols = '0;
    logic [AW-1:0]   baseAddr = '0;
    logic            busy, done, error;

    matrix_ascii_tx_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    matrix_ascii_tx #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DIM_WIDTH(DIMW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rows      (rows),
        .cols      (cols),
        .base_addr (baseAddr),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    int    checkCount = 0, failCount = 0;
    int    readyMode = 0;
    int    cyc = 0, startCyc = 0, lastDoneCyc = 0;
    int    doneCount = 0, errorCount = 0, validCycles = 0, stallViol = 0, busyAtDone = 0;
    int    d0, e0;
    string rxStr = "", addrLog = "";
    logic  prevStall = 1'b0, wasBusy = 1'b0;
    logic [7:0]    prevData = '0;
    logic [AW-1:0] lastAddr = '0;

    localparam string T1 = "2 2\n1 2\n3 4\n";

    always @(posedge clk) begin
        cyc <= cyc + 1;
        bus.storage_rd_data <= mem[bus.storage_rd_addr];
    end

    always @(posedge clk) begin
        #1;
        case (readyMode)
            0:       bus.uart_tx_ready = 1'b1;
            1:       bus.uart_tx_ready = !bus.uart_tx_ready;
            2:       bus.uart_tx_ready = 1'($urandom_range(0, 1));
            default: bus.uart_tx_ready = 1'b0;
        endcase
    end

    // Observes the DUT mid-cycle; a byte seen with valid&&ready is taken at the next edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prevStall && (!bus.uart_tx_valid || bus.uart_tx_data != prevData)) stallViol++;
            if (bus.uart_tx_valid) validCycles++;
            if (bus.uart_tx_valid && bus.uart_tx_ready) rxStr = {rxStr, $sformatf("%c", bus.uart_tx_data)};
            if (done) begin
                doneCount++;
                lastDoneCyc = cyc;
                if (busy) busyAtDone++;
            end
            if (error) errorCount++;
            if (busy && (!wasBusy || bus.storage_rd_addr != lastAddr))
                addrLog = (addrLog.len() == 0) ? $sformatf("%0d", bus.storage_rd_addr)
                                               : $sformatf("%s,%0d", addrLog, bus.storage_rd_addr);
            prevStall = bus.uart_tx_valid && !bus.uart_tx_ready;
            prevData  = bus.uart_tx_data;
            wasBusy   = busy;
            lastAddr  = bus.storage_rd_addr;
        end else begin
            prevStall = 1'b0;
            wasBusy   = 1'b0;
        end
    end

    function automatic string escNl(input string s);
        string o = "";
        for (int i = 0; i < s.len(); i++)
            o = (s[i] == 8'h0A) ? {o, "\\n"} : {o, $sformatf("%c", s[i])};
        return o;
    endfunction

    function automatic string num(input longint v);
        return $sformatf("%0d", v);
    endfunction

    task automatic checkOutput(input string tag, input string got, input string exp);
        checkCount++;
        if (got != exp) begin
            failCount++;
            $display("[TB] FAIL %s: got=%s expected=%s", tag, escNl(got), escNl(exp));
        end
    endtask

    // Starts one transfer and waits (bounded) for done; glitchAt>=0 pulses a bogus start mid-run.
    task automatic applyStimulus(input int r, input int c, input int base, input int budget, input int glitchAt);
        bit timedOut = 1'b1;
        rxStr = ""; addrLog = ""; validCycles = 0; stallViol = 0;
        d0 = doneCount; e0 = errorCount;
        @(posedge clk); #1;
        rows = DIMW'(r); cols = DIMW'(c); baseAddr = AW'(base); start = 1'b1; startCyc = cyc;
        @(posedge clk); #1;
        start = 1'b0; rows = '0; cols = '0; baseAddr = '0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (glitchAt == i) begin
                start = 1'b1; rows = 8'd1; cols = 8'd1; baseAddr = 14'd5;
            end else begin
                start = 1'b0;
            end
            if (doneCount != d0) begin
                timedOut = 1'b0;
                break;
            end
        end
        start = 1'b0;
        if (timedOut) checkOutput("done_timeout", "timeout", "done");
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3; mem[3] = 32'd4;
        mem[8] = -32'sd5; mem[9] = 32'd0; mem[10] = 32'd2147483647;
        mem[20] = 32'h8000_0000;
        for (int i = 0; i < 10; i++) mem[30+i] = 32'(i);
        mem[(1<<AW)-1] = 32'd7;
        bus.uart_tx_ready = 1'b1;

        repeat (3) @(negedge clk);
        checkOutput("rst_valid", num(bus.uart_tx_valid), "0");
        checkOutput("rst_data", num(bus.uart_tx_data), "0");
        checkOutput("rst_addr", num(bus.storage_rd_addr), "0");
        checkOutput("rst_busy_done_err", num({busy, done, error}), "0");
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_busy", num(busy), "0");

        readyMode = 0;
        applyStimulus(2, 2, 0, 500, -1);
        checkOutput("t1_bytes", rxStr, T1);
        checkOutput("t1_addr_seq", addrLog, "0,1,2,3");
        checkOutput("t1_done", num(doneCount - d0), "1");
        checkOutput("t1_error", num(errorCount - e0), "0");
        checkOutput("t1_busy_at_done", num(busyAtDone), "0");

        applyStimulus(1, 3, 8, 500, -1);
        checkOutput("t2_bytes", rxStr, "1 3\n-5 0 2147483647\n");
        checkOutput("t2_addr_seq", addrLog, "8,9,10");

        applyStimulus(1, 1, 20, 500, -1);
        checkOutput("t3_bytes", rxStr, "1 1\n-2147483648\n");

        readyMode = 1;
        applyStimulus(2, 2, 0, 1000, -1);
        checkOutput("t4_toggle_bytes", rxStr, T1);
        checkOutput("t4_toggle_stable", num(stallViol), "0");

        readyMode = 2;
        applyStimulus(2, 2, 0, 2000, -1);
        checkOutput("t4_rand_bytes", rxStr, T1);
        checkOutput("t4_rand_stable", num(stallViol), "0");

        readyMode = 0;
        applyStimulus(0, 3, 0, 10, -1);
        checkOutput("t5_no_valid", num(validCycles), "0");
        checkOutput("t5_done", num(doneCount - d0), "1");
        checkOutput("t5_error", num(errorCount - e0), "1");
        checkOutput("t5_latency_ok", num(lastDoneCyc - startCyc <= 3), "1");

        applyStimulus(4, 0, 0, 10, -1);
        checkOutput("t5b_no_valid", num(validCycles), "0");
        checkOutput("t5b_error", num(errorCount - e0), "1");

        applyStimulus(2, 2, 0, 500, 5);
        checkOutput("t7_start_ignored_bytes", rxStr, T1);
        checkOutput("t7_single_done", num(doneCount - d0), "1");

        applyStimulus(1, 2, (1<<AW)-1, 500, -1);
        checkOutput("t8_wrap_bytes", rxStr, "1 2\n7 1\n");
        checkOutput("t8_wrap_addr", addrLog, "16383,0");

        applyStimulus(10, 1, 30, 1000, -1);
        checkOutput("t9_column_bytes", rxStr, "10 1\n0\n1\n2\n3\n4\n5\n6\n7\n8\n9\n");

        // Abort a 2x2 run once a few bytes are out, while a byte is on the bus.
        rxStr = ""; d0 = doneCount;
        @(posedge clk); #1;
        rows = 8'd2; cols = 8'd2; baseAddr = '0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (rxStr.len() >= 6 && bus.uart_tx_valid) break;
        end
        checkOutput("t6_valid_before_reset", num(bus.uart_tx_valid), "1");
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_valid_async", num(bus.uart_tx_valid), "0");
        checkOutput("t6_busy_async", num(busy), "0");
        repeat (3) @(negedge clk);
        checkOutput("t6_no_done", num(doneCount - d0), "0");
        @(posedge clk); #1 rst_n = 1'b1;
        applyStimulus(2, 2, 0, 500, -1);
        checkOutput("t6_rerun_bytes", rxStr, T1);
        checkOutput("t6_rerun_done", num(doneCount - d0), "1");

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end
endmodule
